seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg_scan_tick.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: segment patterns,
// scan state encoding and the BCD-to-segment decoder.
package seg_pkg;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_e;

   // Non-BCD nibbles render as a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
      case (nibble)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Free-running prescaler shared by the BLANK and SHOW slots; tc_c flags the
// last cycle of a slot and the counter wraps to zero on the following edge.
module seg_scan_tick #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic [W-1:0] term,
   output logic         tc_c
);

   logic [W-1:0] cnt;

   assign tc_c = (cnt == term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tc_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered BCD value.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned TICK_DIV     = 1000,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   output logic [6:0]                seg_out,
   output logic [NUM_DIGITS-1:0]     dig_en,
   output logic                      frame_done
);

   localparam int unsigned DW         = 4 * NUM_DIGITS;
   localparam int unsigned IW         = $clog2(NUM_DIGITS);
   localparam int unsigned PMAX       = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
   localparam int unsigned PW         = $clog2(PMAX + 1);
   localparam int unsigned BLANK_TERM = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam scan_state_e FIRST      = (BLANK_CYCLES > 0) ? BLANK : SHOW;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

   scan_state_e            state, state_d;
   logic [IW-1:0]          idx, idx_d;
   logic [DW-1:0]          disp, disp_d;
   logic [DW-1:0]          shadow, shadow_d;
   logic                   pend, pend_d;
   logic [6:0]             seg_d;
   logic [NUM_DIGITS-1:0]  dig_d;
   logic                   fd_d;
   logic                   boundary_c;
   logic                   blank_digit_c;
   logic                   tick_clear_c;
   logic [PW-1:0]          tick_term_c;
   logic                   tc_c;

   assign tick_clear_c = (state == IDLE) || !enable;
   assign tick_term_c  = (state == SHOW) ? PW'(TICK_DIV - 1) : PW'(BLANK_TERM);

   seg_scan_tick #(.W(PW)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tick_clear_c),
      .term  (tick_term_c),
      .tc_c  (tc_c)
   );

   // Next-state, buffer update and next-output computation.
   always_comb begin
      state_d       = state;
      idx_d         = idx;
      disp_d        = disp;
      shadow_d      = shadow;
      pend_d        = pend;
      fd_d          = 1'b0;
      boundary_c    = 1'b0;
      seg_d         = SEG_OFF;
      dig_d         = '0;
      blank_digit_c = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         case (state)
            IDLE: begin
               boundary_c = 1'b1;
               idx_d      = '0;
               state_d    = FIRST;
            end
            BLANK: begin
               if (tc_c) state_d = SHOW;
            end
            SHOW: begin
               if (tc_c) begin
                  state_d = FIRST;
                  if (idx == LAST_IDX) begin
                     fd_d       = 1'b1;
                     boundary_c = 1'b1;
                     idx_d      = '0;
                  end else begin
                     idx_d = idx + IW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (load) begin
         shadow_d = value_in;
         pend_d   = 1'b1;
      end

      // A load landing on the boundary bypasses the shadow.
      if (boundary_c) begin
         disp_d = load ? value_in : (pend ? shadow : disp);
         pend_d = 1'b0;
      end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      blank_digit_c = (idx_d != '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (IW'(j) >= idx_d && disp_d[4*j +: 4] != 4'd0) blank_digit_c = 1'b0;
      end
`endif

      if (state_d == SHOW) begin
         dig_d = NUM_DIGITS'(1) << idx_d;
         seg_d = blank_digit_c ? SEG_OFF : seg_decode(disp_d[{idx_d, 2'b00} +: 4]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         disp       <= '0;
         shadow     <= '0;
         pend       <= 1'b0;
         seg_out    <= SEG_OFF;
         dig_en     <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         disp       <= disp_d;
         shadow     <= shadow_d;
         pend       <= pend_d;
         seg_out    <= seg_d;
         dig_en     <= dig_d;
         frame_done <= fd_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, TICK_DIV=4, BLANK_CYCLES=1);
// each table row describes one 20-cycle frame plus an optional load/disable.
module tb_seg_scan_ctrl;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
   localparam logic [6:0] S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111;
   localparam logic [6:0] S9 = 7'b1111011, SD = 7'b0000001;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z0 = 7'b0000000;
`else
   localparam logic [6:0] Z0 = S0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic [6:0]  seg_out;
   logic [3:0]  dig_en;
   logic        frame_done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value_in   (value_in),
      .seg_out    (seg_out),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   typedef struct {
      string           nm;
      logic [3:0][6:0] exp;
      int              ld_t;
      logic [15:0]     ld_val;
      int              drop_t;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [3:0][6:0] pat(input logic [6:0] d0, input logic [6:0] d1,
                                           input logic [6:0] d2, input logic [6:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic [3:0] e_dig, input logic [6:0] e_seg,
                          input logic e_fd);
      chk({nm, " dig_en"}, 32'(dig_en), 32'(e_dig));
      chk({nm, " seg_out"}, 32'(seg_out), 32'(e_seg));
      chk({nm, " frame_done"}, 32'(frame_done), 32'(e_fd));
   endtask

   // Starts just after the blank slot preceding digit 0 has been sampled.
   task automatic run_frame(input string nm, input logic [3:0][6:0] exp, input int ld_t,
                            input logic [15:0] ld_val, input int drop_t);
      for (int t = 0; t < 20; t++) begin
         int d;
         d = t / 5;
         step();
         load = 1'b0;
         if (t % 5 != 4) chk_out($sformatf("%s t%0d", nm, t), 4'(1 << d), exp[d], 1'b0);
         else            chk_out($sformatf("%s t%0d", nm, t), 4'b0000, 7'b0, d == 3);
         if (t == ld_t) begin
            load     = 1'b1;
            value_in = ld_val;
         end
         if (t == drop_t) begin
            enable = 1'b0;
            step();
            load = 1'b0;
            chk_out({nm, " disabled"}, 4'b0000, 7'b0, 1'b0);
            return;
         end
      end
   endtask

   initial begin
      tbl[0] = '{"f1234",     pat(S4, S3, S2, S1), -1, 16'h0000, -1};
      tbl[1] = '{"f1234_ld",  pat(S4, S3, S2, S1),  5, 16'h5678, -1};
      tbl[2] = '{"f5678",     pat(S8, S7, S6, S5), 15, 16'hF0A9, -1};
      tbl[3] = '{"fF0A9",     pat(S9, SD, S0, SD), 10, 16'h0042, -1};
      tbl[4] = '{"f0042",     pat(S2, S4, Z0, Z0),  0, 16'h0000, -1};
      tbl[5] = '{"f0000_bnd", pat(S0, Z0, Z0, Z0), 18, 16'h9999, -1};
      tbl[6] = '{"f9999_drp", pat(S9, S9, S9, S9), -1, 16'h0000, 10};

      rst_n    = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      value_in = '0;
      #2;
      chk_out("reset", 4'b0000, 7'b0, 1'b0);
      #10 rst_n = 1'b1;

      step();
      load     = 1'b1;
      value_in = 16'h1234;
      step();
      load   = 1'b0;
      enable = 1'b1;
      step();
      chk_out("first blank", 4'b0000, 7'b0, 1'b0);

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i].nm, tbl[i].exp, tbl[i].ld_t, tbl[i].ld_val, tbl[i].drop_t);

      // Loads while idle: the second overwrites the first.
      load     = 1'b1;
      value_in = 16'h1111;
      step();
      value_in = 16'h2580;
      step();
      load = 1'b0;
      step();
      chk_out("idle hold", 4'b0000, 7'b0, 1'b0);
      enable = 1'b1;
      step();
      chk_out("restart blank", 4'b0000, 7'b0, 1'b0);
      run_frame("f2580_drp", pat(S0, S8, S5, S2), -1, 16'h0000, 18);

      enable = 1'b1;
      step();
      chk_out("restart2 blank", 4'b0000, 7'b0, 1'b0);
      run_frame("f2580", pat(S0, S8, S5, S2), -1, 16'h0000, -1);

      // Asynchronous reset in the middle of a SHOW slot.
      step();
      step();
      chk_out("pre-reset show", 4'b0001, S0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_out("async reset", 4'b0000, 7'b0, 1'b0);
      #2 rst_n = 1'b1;
      step();
      chk_out("post-reset blank", 4'b0000, 7'b0, 1'b0);
      run_frame("f_after_rst", pat(S0, Z0, Z0, Z0), -1, 16'h0000, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
